// File: rtl/sd_seq_pkg.sv
// Shared types, register map and command-sequence ROM for the SD block sequencer.
// The ROM yields {addr, data} for each register write of one block command.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_POLL_WAIT = 3'd2,
    S_POLL_RD   = 3'd3,
    S_CLEAR     = 3'd4,
    S_FINISH    = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_CTRL    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } seq_err_t;

  localparam logic [6:0] REG_ARG0        = 7'h00;
  localparam logic [6:0] REG_ARG1        = 7'h01;
  localparam logic [6:0] REG_ARG2        = 7'h02;
  localparam logic [6:0] REG_ARG3        = 7'h03;
  localparam logic [6:0] REG_CMD_SET     = 7'h04;
  localparam logic [6:0] REG_CMD_IDX     = 7'h05;
  localparam logic [6:0] REG_BLK_SIZE    = 7'h44;
  localparam logic [6:0] REG_BLK_CNT     = 7'h45;
  localparam logic [6:0] REG_BLK_SIZE_HI = 7'h48;

  localparam logic [7:0] CMD_READ_SINGLE  = 8'd17;
  localparam logic [7:0] CMD_WRITE_SINGLE = 8'd24;
  localparam logic [7:0] CMD_SET_WRITE    = 8'h80;
  localparam logic [7:0] CMD_SET_READ     = 8'h7D;

  localparam logic [3:0] ISSUE_LAST = 4'd8;

  // The final write to ARG0 is what kicks off the command in the controller.
  function automatic logic [14:0] step_rom(input logic [3:0] step, input logic wr,
                                           input logic [31:0] lba);
    logic [14:0] w;
    case (step)
      4'd0:    w = {REG_BLK_SIZE_HI, 8'h00};
      4'd1:    w = {REG_BLK_SIZE, 8'hFF};
      4'd2:    w = {REG_BLK_CNT, 8'h01};
      4'd3:    w = {REG_CMD_IDX, wr ? CMD_WRITE_SINGLE : CMD_READ_SINGLE};
      4'd4:    w = {REG_CMD_SET, wr ? CMD_SET_WRITE : CMD_SET_READ};
      4'd5:    w = {REG_ARG3, lba[31:24]};
      4'd6:    w = {REG_ARG2, lba[23:16]};
      4'd7:    w = {REG_ARG1, lba[15:8]};
      default: w = {REG_ARG0, lba[7:0]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sd_seq_poll_timer.sv
// Poll-gap down-counter and poll-phase timeout counter for the block sequencer.
// start reloads the gap; clear zeroes the timeout; run lets the timeout count.
module sd_seq_poll_timer #(
  parameter int POLL_GAP = 64,
  parameter int TIMEOUT  = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic run,
  output logic gap_done,
  output logic timed_out
);

  logic [15:0] gap_cnt;
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (start)
        gap_cnt <= 16'(POLL_GAP - 1);
      else if (gap_cnt != 16'd0)
        gap_cnt <= gap_cnt - 16'd1;
      if (clear)
        tmo_cnt <= '0;
      else if (run && !timed_out)
        tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign gap_done  = (gap_cnt == 16'd0);
  // Fires in the TIMEOUT-th cycle spent polling.
  assign timed_out = run && (tmo_cnt >= 32'(TIMEOUT - 1));

endmodule

// File: rtl/sd_block_sequencer.sv
// Drives the sdc_controller register sequence for one block read/write and polls
// status to completion; passes host register traffic through while idle.
module sd_block_sequencer
  import sd_seq_pkg::*;
#(
  parameter logic [6:0] STATUS_ADDR = 7'h30,
  parameter int         RD_LAT      = 2,
  parameter int         POLL_GAP    = 64,
  parameter int         TIMEOUT     = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_lba,
  output logic        done,
  output logic [1:0]  err,
  input  logic [6:0]  host_addr,
  input  logic        host_we,
  input  logic [7:0]  host_data,
  output logic        host_collision,
  output logic [6:0]  sd_addr,
  output logic        sd_we,
  output logic [7:0]  sd_data_o,
  input  logic [7:0]  sd_data_i,
  output logic [2:0]  state_dbg
);

  // Handshake: a request is taken on any cycle where req_valid and req_ready are
  // both high; req_ready is high only in IDLE.

  seq_state_t  state, nxt_state;
  logic [3:0]  step, nxt_step;
  logic [3:0]  rd_cnt, nxt_rd_cnt;
  logic [1:0]  err_q, nxt_err;
  logic        coll_q, nxt_coll;
  logic        wr_q;
  logic [31:0] lba_q;
  logic [6:0]  sd_addr_q, nxt_sd_addr;
  logic        sd_we_q, nxt_sd_we;
  logic [7:0]  sd_data_q, nxt_sd_data;
  logic [14:0] rom_word;
  logic        accept;
  logic        tmr_start, tmr_clear, tmr_run, gap_done, timed_out;

  assign accept  = req_valid && (state == S_IDLE);
  assign tmr_run = (state == S_POLL_WAIT) || (state == S_POLL_RD);

  sd_seq_poll_timer #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (tmr_start),
    .clear     (tmr_clear),
    .run       (tmr_run),
    .gap_done  (gap_done),
    .timed_out (timed_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      rd_cnt    <= '0;
      err_q     <= ERR_OK;
      coll_q    <= 1'b0;
      wr_q      <= 1'b0;
      lba_q     <= '0;
      sd_addr_q <= '0;
      sd_we_q   <= 1'b0;
      sd_data_q <= '0;
    end else begin
      state     <= nxt_state;
      step      <= nxt_step;
      rd_cnt    <= nxt_rd_cnt;
      err_q     <= nxt_err;
      coll_q    <= nxt_coll;
      sd_addr_q <= nxt_sd_addr;
      sd_we_q   <= nxt_sd_we;
      sd_data_q <= nxt_sd_data;
      if (accept) begin
        wr_q  <= req_write;
        lba_q <= req_lba;
      end
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_step    = step;
    nxt_rd_cnt  = rd_cnt;
    nxt_err     = err_q;
    nxt_coll    = coll_q;
    nxt_sd_addr = '0;
    nxt_sd_we   = 1'b0;
    nxt_sd_data = '0;
    tmr_start   = 1'b0;
    tmr_clear   = 1'b0;
    if (state != S_IDLE && host_we)
      nxt_coll = 1'b1;
    case (state)
      S_IDLE: if (req_valid) begin
        nxt_state = S_ISSUE;
        nxt_step  = '0;
        nxt_coll  = 1'b0;
        nxt_err   = ERR_OK;
      end
      S_ISSUE: if (step == ISSUE_LAST) begin
        nxt_state = S_POLL_WAIT;
        tmr_start = 1'b1;
        tmr_clear = 1'b1;
      end else begin
        nxt_step = step + 4'd1;
      end
      S_POLL_WAIT: if (timed_out) begin
        nxt_err   = ERR_TIMEOUT;
        nxt_state = S_CLEAR;
      end else if (gap_done) begin
        nxt_state  = S_POLL_RD;
        nxt_rd_cnt = '0;
      end
      S_POLL_RD: if (timed_out) begin
        nxt_err   = ERR_TIMEOUT;
        nxt_state = S_CLEAR;
      end else if (rd_cnt == 4'(RD_LAT)) begin
        if (sd_data_i[1]) begin
          nxt_err   = ERR_CTRL;
          nxt_state = S_CLEAR;
        end else if (sd_data_i[0]) begin
          nxt_err   = ERR_OK;
          nxt_state = S_CLEAR;
        end else begin
          nxt_state = S_POLL_WAIT;
          tmr_start = 1'b1;
        end
      end else begin
        nxt_rd_cnt = rd_cnt + 4'd1;
      end
      S_CLEAR:  nxt_state = S_FINISH;
      S_FINISH: nxt_state = S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase
    // Bus outputs are computed from the next state so they are registered yet
    // line up with the cycle the state is entered.
    rom_word = step_rom(nxt_step, accept ? req_write : wr_q, accept ? req_lba : lba_q);
    case (nxt_state)
      S_ISSUE: begin
        nxt_sd_addr = rom_word[14:8];
        nxt_sd_data = rom_word[7:0];
        nxt_sd_we   = 1'b1;
      end
      S_POLL_RD: nxt_sd_addr = STATUS_ADDR;
      S_CLEAR: begin
        nxt_sd_addr = STATUS_ADDR;
        nxt_sd_data = 8'h03;
        nxt_sd_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready      = (state == S_IDLE);
  assign done           = (state == S_FINISH);
  assign err            = done ? err_q : ERR_OK;
  assign host_collision = coll_q;
  assign sd_addr        = (state == S_IDLE) ? host_addr : sd_addr_q;
  assign sd_we          = (state == S_IDLE) ? host_we   : sd_we_q;
  assign sd_data_o      = (state == S_IDLE) ? host_data : sd_data_q;
  assign state_dbg      = state;

endmodule
